// File: rtl/step_seq_pkg.sv
// Shared constants for the step clock sequencer: FSM states, register map, CTRL/STATUS bits.
package step_seq_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

    localparam logic [1:0] AddrLevel = 2'd0;
    localparam logic [1:0] AddrCount = 2'd1;
    localparam logic [1:0] AddrHalf  = 2'd2;
    localparam logic [1:0] AddrCtrl  = 2'd3;

    localparam int unsigned CtrlStart     = 0;
    localparam int unsigned CtrlAbort     = 1;
    localparam int unsigned CtrlClearDone = 2;
    localparam int unsigned CtrlIrqEn     = 3;

    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatDone    = 1;
    localparam int unsigned StatAborted = 2;
    localparam int unsigned StatIrqEn   = 3;

    // Timer reload for a half-period: a programmed 0 behaves like 1.
    function automatic logic [31:0] reload_value(input logic [31:0] half);
        return (half == 32'd0) ? 32'd0 : half - 32'd1;
    endfunction

endpackage

// File: rtl/half_period_timer.sv
// Loadable down-counter that times one phase of the stepping clock; expire is high at zero.
module half_period_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] load_value,
    output logic             expire
);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (run && count_q != '0) begin
            count_d = count_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/step_clock_sequencer.sv
// Avalon-MM stepping-clock generator for the solver; optional irq with STEP_SEQ_IRQ_EN.
module step_clock_sequencer
    import step_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        busy
`ifdef STEP_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [1:0]       state_q, state_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             irq_en_q;

    logic             wr_en, wr_level, wr_count, wr_half, wr_ctrl;
    logic             start, abort, clear_done;
    logic             tmr_load, tmr_run, tmr_expire;
    logic [DIV_W-1:0] tmr_reload;
    logic             unused_wdata;

    assign wr_en      = chipselect & ~write_n;
    assign wr_level   = wr_en && (address == AddrLevel);
    assign wr_count   = wr_en && (address == AddrCount);
    assign wr_half    = wr_en && (address == AddrHalf);
    assign wr_ctrl    = wr_en && (address == AddrCtrl);
    assign start      = wr_ctrl & writedata[CtrlStart];
    assign abort      = wr_ctrl & writedata[CtrlAbort];
    assign clear_done = wr_ctrl & writedata[CtrlClearDone];
    assign unused_wdata = ^writedata;

    assign tmr_reload = DIV_W'(reload_value(32'(half_q)));

    half_period_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (tmr_load),
        .run       (tmr_run),
        .load_value(tmr_reload),
        .expire    (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        count_d   = count_q;
        half_d    = half_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        tmr_load  = 1'b0;
        tmr_run   = 1'b0;

        if (wr_half) half_d = writedata[DIV_W-1:0];
        if (clear_done) done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (wr_level) out_d = writedata[0];
                if (wr_count) count_d = writedata[CNT_W-1:0];
                // Abort in the same write cancels the start.
                if (start && !abort && count_q != '0) begin
                    state_d   = StHigh;
                    out_d     = 1'b1;
                    tmr_load  = 1'b1;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            StHigh: begin
                if (abort) begin
                    state_d   = StIdle;
                    out_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (tmr_expire) begin
                    state_d  = StLow;
                    out_d    = 1'b0;
                    tmr_load = 1'b1;
                    count_d  = count_q - CNT_W'(1);
                end else begin
                    tmr_run = 1'b1;
                end
            end
            StLow: begin
                if (abort) begin
                    state_d   = StIdle;
                    out_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (tmr_expire) begin
                    if (count_q != '0) begin
                        state_d  = StHigh;
                        out_d    = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmr_run = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            out_q     <= 1'b0;
            count_q   <= '0;
            half_q    <= DIV_W'(1);
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            count_q   <= count_d;
            half_q    <= half_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

`ifdef STEP_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en_q <= writedata[CtrlIrqEn];
        end
    end

    assign irq = done_q & irq_en_q;
`else
    assign irq_en_q = 1'b0;
`endif

    assign out_port = out_q;
    assign busy     = (state_q != StIdle);

    always_comb begin
        readdata = '0;
        case (address)
            AddrLevel: readdata[0] = out_q;
            AddrCount: readdata = 32'(count_q);
            AddrHalf:  readdata = 32'(half_q);
            default: begin
                readdata[StatBusy]    = busy;
                readdata[StatDone]    = done_q;
                readdata[StatAborted] = aborted_q;
                readdata[StatIrqEn]   = irq_en_q;
            end
        endcase
    end

endmodule

// File: tb/tb_step_clock_sequencer.sv
// Self-checking bench for step_clock_sequencer; build with STEP_SEQ_IRQ_EN to cover irq.
module tb_step_clock_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        busy;
`ifdef STEP_SEQ_IRQ_EN
    logic        irq;
    localparam logic [31:0] EnRd = 32'h8;
`else
    localparam logic [31:0] EnRd = 32'h0;
`endif

    localparam logic [1:0] ALevel = 2'd0;
    localparam logic [1:0] ACount = 2'd1;
    localparam logic [1:0] AHalf  = 2'd2;
    localparam logic [1:0] ACtrl  = 2'd3;
    localparam logic [31:0] WStart = 32'h1;
    localparam logic [31:0] WAbort = 32'h2;
    localparam logic [31:0] WClear = 32'h4;
    localparam logic [31:0] WIrqEn = 32'h8;

    int tests = 0;
    int fails = 0;
    logic [31:0] d;

    step_clock_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .busy      (busy)
`ifdef STEP_SEQ_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; the write is sampled at the following posedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = v;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
        @(negedge clk);
    endtask

    // Reference: after start edge T, at edge T+j the output is high iff (j mod 2H') < H',
    // busy while j < 2*H'*N. An abort sampled at edge T+m ends everything at that edge.
    // noise: -1 none, 0 LEVEL=0, 1 COUNT write, 2 start; issued at edge T+2 while busy.
    task automatic run_burst(input int n, input int h, input int abort_m, input int noise);
        int hh, total, last, rem, k;
        logic eo, eb;
        hh = (h == 0) ? 1 : h;
        total = 2 * hh * n;
        last = (abort_m != 0) ? abort_m : total;
        wr(ACount, 32'(n));
        wr(AHalf, 32'(h));
        wr(ACtrl, WStart | WIrqEn);
`ifdef STEP_SEQ_IRQ_EN
        check("irq_drop_on_start", 32'(irq), 32'd0);
`endif
        for (int j = 0; j <= last; j++) begin
            if (abort_m != 0 && j >= abort_m) begin
                eo = 1'b0; eb = 1'b0;
            end else if (j < total) begin
                eo = ((j % (2 * hh)) < hh); eb = 1'b1;
            end else begin
                eo = 1'b0; eb = 1'b0;
            end
            check($sformatf("out n=%0d h=%0d j=%0d", n, h, j), 32'(out_port), 32'(eo));
            check($sformatf("busy n=%0d h=%0d j=%0d", n, h, j), 32'(busy), 32'(eb));
            chipselect = 1'b0; write_n = 1'b1;
            if (abort_m != 0 && j == abort_m - 1) begin
                chipselect = 1'b1; write_n = 1'b0; address = ACtrl;
                writedata = WAbort | WIrqEn | ($urandom_range(0, 1) != 0 ? WStart : 32'h0);
            end else if (noise >= 0 && j == 1 && (abort_m == 0 || abort_m > 2)) begin
                chipselect = 1'b1; write_n = 1'b0;
                case (noise)
                    0:       begin address = ALevel; writedata = 32'h0; end
                    1:       begin address = ACount; writedata = $urandom; end
                    default: begin address = ACtrl; writedata = WStart | WIrqEn; end
                endcase
            end
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1;
        if (abort_m != 0) begin
            k = abort_m - 1;
            rem = n - ((k >= hh) ? ((k - hh) / (2 * hh) + 1) : 0);
            rd(ACtrl, d);  check("status_after_abort", d, 32'h4 | EnRd);
            rd(ACount, d); check("count_after_abort", d, 32'(rem));
        end else begin
            rd(ACtrl, d);  check("status_after_done", d, 32'h2 | EnRd);
            rd(ACount, d); check("count_after_done", d, 32'd0);
        end
`ifdef STEP_SEQ_IRQ_EN
        check("irq_after_burst", 32'(irq), (abort_m == 0) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        int n, h, m, nz;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_out", 32'(out_port), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef STEP_SEQ_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        rd(ALevel, d); check("rst_level", d, 32'd0);
        rd(ACount, d); check("rst_count", d, 32'd0);
        rd(AHalf, d);  check("rst_half", d, 32'd1);
        rd(ACtrl, d);  check("rst_status", d, 32'd0);

        run_burst(3, 2, 0, -1);

        wr(ACtrl, WClear | WIrqEn);
        check("clear_done_busy", 32'(busy), 32'd0);
`ifdef STEP_SEQ_IRQ_EN
        check("irq_after_clear", 32'(irq), 32'd0);
`endif
        rd(ACtrl, d); check("status_after_clear", d, EnRd);

        run_burst(5, 4, 10, -1);

        wr(ACount, 32'd0);
        wr(ACtrl, WStart | WIrqEn);
        check("start_cnt0_busy", 32'(busy), 32'd0);
        rd(ACtrl, d); check("start_cnt0_status", d, 32'h4 | EnRd);

        run_burst(2, 0, 0, -1);

        wr(ACtrl, WAbort | WIrqEn);
        check("idle_abort_busy", 32'(busy), 32'd0);
        rd(ACtrl, d); check("idle_abort_status", d, 32'h2 | EnRd);

        wr(ACount, 32'd3);
        wr(ACtrl, WStart | WAbort | WIrqEn);
        check("start_abort_busy", 32'(busy), 32'd0);
        rd(ACount, d); check("start_abort_count", d, 32'd3);
        rd(ACtrl, d);  check("start_abort_status", d, 32'h2 | EnRd);

        wr(ALevel, 32'd1);
        check("level_out", 32'(out_port), 32'd1);
        rd(ALevel, d); check("level_read", d, 32'd1);

        run_burst(2, 3, 0, 0);
        run_burst(3, 1, 0, 1);
        run_burst(2, 2, 0, 2);

        for (int i = 0; i < 8; i++) begin
            n = int'($urandom_range(1, 6));
            h = int'($urandom_range(0, 5));
            m = 0;
            if ($urandom_range(0, 1) != 0)
                m = int'($urandom_range(1, 2 * ((h == 0) ? 1 : h) * n));
            nz = int'($urandom_range(0, 3)) - 1;
            run_burst(n, h, m, nz);
        end

        wr(ACount, 32'd4);
        wr(AHalf, 32'd3);
        wr(ACtrl, WStart | WIrqEn);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midburst_rst_out", 32'(out_port), 32'd0);
        check("midburst_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(ACount, d); check("midburst_rst_count", d, 32'd0);
        rd(AHalf, d);  check("midburst_rst_half", d, 32'd1);
        rd(ACtrl, d);  check("midburst_rst_status", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
